// File: rtl/gate_pkg.sv
// Shared constants and types for the gate exerciser: truth-table selectors,
// FSM state encoding and settle-counter width.
package gate_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_NAND = 2;
  localparam int unsigned OP_NOR  = 3;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_XNOR = 5;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic gate_eval(input int unsigned op, input logic x, input logic y);
    logic r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      default: r = ~(x ^ y);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden gate: expected output of the gate under test for the
// current (a,b) drive, selected by GATE_OP.
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int unsigned GATE_OP = OP_XNOR
) (
  input  logic a,
  input  logic b,
  output logic exp_c
);

  always_comb begin
    exp_c = gate_eval(GATE_OP, a, b);
  end

endmodule

// File: rtl/gate_exerciser.sv
// Drives the four (a,b) vectors into a 2-input gate, samples c after a settle
// time and counts mismatches. Define GATE_EXERCISER_STOP_ON_FAIL_EN to abort on first mismatch.
//   state  | meaning
//   IDLE   | waiting for start; results held
//   DRIVE  | vector applied, settle counter running
//   SAMPLE | compare c with expected value
//   DONE   | one-cycle done pulse, pass valid
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int unsigned GATE_OP       = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [2:0]       err_q, err_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             exp_c, mismatch;
  logic [1:0]       vec_nxt;

  gate_ref_model #(.GATE_OP(GATE_OP)) u_ref (
    .a     (a_q),
    .b     (b_q),
    .exp_c (exp_c)
  );

  assign mismatch = (c != exp_c);
  assign vec_nxt  = vec_idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_idx_d = vec_idx_q;
    err_d     = err_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          cnt_d     = CNT_LOAD;
          vec_idx_d = 2'd0;
          err_d     = 3'd0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        // err_count tops out at 4, so 3 bits never wrap
        if (mismatch) err_d = err_q + 3'd1;
        if ((vec_idx_q == 2'd3) || (STOP_EN && mismatch)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d   = DRIVE;
          cnt_d     = CNT_LOAD;
          vec_idx_d = vec_nxt;
          a_d       = vec_nxt[1];
          b_d       = vec_nxt[0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_idx_q <= 2'd0;
      err_q     <= 3'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_idx_q <= vec_idx_d;
      err_q     <= err_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: the gate under test is a 4-entry truth table indexed
// by {a,b}; expected timeline and results come from a per-run arithmetic model.
module tb_gate_exerciser;

  localparam int S  = 1;
  localparam int OP = 5;

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, a, b, c, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] vec_idx;
  logic [3:0] tt;

  int checks = 0;
  int errors = 0;

  assign c = tt[{a, b}];

  always #5 clk = ~clk;

  gate_exerciser #(.GATE_OP(OP), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_idx   (vec_idx)
  );

  function automatic bit ref_gate(input bit x, input bit y);
    case (OP)
      0:       return x && y;
      1:       return x || y;
      2:       return !(x && y);
      3:       return !(x || y);
      4:       return x != y;
      default: return x == y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start, let the accept edge pass, then leave start at 'hold'.
  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    step();
    start = hold;
  endtask

  // Called 1 time unit after the accept edge; follows the run to its done pulse.
  task automatic observe_run(input bit toggle, input bit keep);
    int nerr, first_fail, nrun, done_t, vi;
    nerr = 0;
    first_fail = -1;
    for (int i = 0; i < 4; i++) begin
      if (tt[i] != ref_gate(i[1], i[0])) begin
        nerr++;
        if (first_fail < 0) first_fail = i;
      end
    end
    if (STOP && first_fail >= 0) begin
      nrun = first_fail + 1;
      nerr = 1;
    end else begin
      nrun = 4;
    end
    done_t = nrun * (S + 1);
    for (int t = 0; t <= done_t; t++) begin
      if (t < done_t) begin
        vi = t / (S + 1);
        chk("run_busy", busy, 1);
        chk("run_done_low", done, 0);
        chk("run_a", a, vi / 2);
        chk("run_b", b, vi % 2);
        chk("run_vec_idx", vec_idx, vi);
        if (toggle) start = 1'($urandom_range(0, 1));
        step();
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_pass", pass, (nerr == 0) ? 1 : 0);
        chk("done_err_count", err_count, nerr);
        chk("done_vec_idx", vec_idx, nrun - 1);
        start = keep;
      end
    end
    if (!keep) begin
      step();
      chk("idle_done_low", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_pass_hold", pass, (nerr == 0) ? 1 : 0);
      chk("idle_err_hold", err_count, nerr);
      chk("idle_vec_hold", vec_idx, nrun - 1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tt    = 4'b1001;
    repeat (2) step();
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", vec_idx, 0);
    rst = 1'b0;
    step();

    // correct XNOR gate
    tt = 4'b1001;
    launch(1'b0);
    observe_run(1'b0, 1'b0);

    // XOR gate: every vector mismatches
    tt = 4'b0110;
    launch(1'b0);
    observe_run(1'b0, 1'b0);

    // c stuck at 1: vectors 01 and 10 mismatch
    tt = 4'b1111;
    launch(1'b0);
    observe_run(1'b0, 1'b0);

    // reset during DRIVE of vector 2, with start also high
    tt = 4'b1001;
    launch(1'b0);
    repeat (2 * (S + 1)) step();
    chk("pre_rst_vec", vec_idx, 2);
    chk("pre_rst_busy", busy, 1);
    rst   = 1'b1;
    start = 1'b1;
    step();
    chk("abort_a", a, 0);
    chk("abort_b", b, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_count, 0);
    chk("abort_vec", vec_idx, 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_stay_idle", busy, 0);
    end

    // start toggling while busy must not restart the run
    tt = 4'($urandom);
    launch(1'b1);
    observe_run(1'b1, 1'b0);

    // start held high: relaunch right after DONE via one IDLE cycle
    tt = 4'b1001;
    launch(1'b1);
    observe_run(1'b0, 1'b1);
    step();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);
    step();
    observe_run(1'b0, 1'b0);

    // randomized gate behaviour
    for (int r = 0; r < 20; r++) begin
      tt = 4'($urandom);
      launch(1'b0);
      observe_run(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
